conv_window_sequencer: RTL and testbench
========================================

# conv_window_sequencer

Frame-level sequencer for the sliding-window convolution datapath. It accepts a raster stream of IMAGE_SIZE×IMAGE_SIZE pixels under a valid/ready handshake and drives the clock enable and circular read/write addresses of the pixel (line) buffers. It flags each cycle in which the buffers hold a complete FILTER_SIZE×FILTER_SIZE window, and reports the window's position. It sits between the pixel source and the pixel buffer / convolution engine and replaces free-running address counters with start/done frame control.

## Interface
- FILTER_SIZE, default 3: window edge length, in pixels; 2 ≤ FILTER_SIZE ≤ IMAGE_SIZE.
- IMAGE_SIZE, default 28: image edge length, in pixels.
- Width A = `LOG2(IMAGE_SIZE) for all address and coordinate ports.

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- rst  in  1  Reset, synchronous, active-high.
- start  in  1  Begin a frame; sampled only in IDLE.
- in_valid  in  1  Source has a pixel.
- in_ready  out  1  Sequencer accepts a pixel this cycle.
- out_ready  in  1  Downstream can take a window next cycle.
- buf_en  out  1  Pixel-buffer clock enable (combinational, = in_valid & in_ready).
- wr_addr  out  A  Line-buffer write address.
- rd_addr  out  A  Line-buffer read address.
- out_valid  out  1  Buffers hold a complete window (registered).
- out_col  out  A  Window top-left column, valid with out_valid.
- out_row  out  A  Window top-left row, valid with out_valid.
- busy  out  1  High in RUN.
- done  out  1  One-cycle pulse after the last pixel is accepted.

## Operation
- States:
  - IDLE: in_ready=0. On start → RUN, and clear x, y, wr_addr=0, rd_addr=1.
  - RUN: in_ready = out_ready.
  - DONE: in_ready=0, done=1 for one cycle → IDLE.
- Accept = in_valid & in_ready. All counters advance only on accept.
- Line-buffer depth D = IMAGE_SIZE−FILTER_SIZE+1.
- wr_addr and rd_addr each increment and wrap from D−1 to 0. rd_addr is always (wr_addr+1) mod D.
- Column counter x wraps IMAGE_SIZE−1 → 0. When x wraps, row counter y increments.
- On accept of pixel (x, y):
  - out_valid ← (x ≥ FILTER_SIZE−1) & (y ≥ FILTER_SIZE−1).
  - out_col ← x−(FILTER_SIZE−1) and out_row ← y−(FILTER_SIZE−1) when that window is valid; otherwise hold.
- No accept → out_valid ← 0. out_valid is therefore a per-window one-cycle pulse.
- Accept of (IMAGE_SIZE−1, IMAGE_SIZE−1) → DONE next cycle. Counters return to 0 on the wrap.
- start while in RUN or DONE is ignored.
- Windows per frame = D².

## Timing
- Reset values: state=IDLE, in_ready=0, buf_en=0, wr_addr=0, rd_addr=1, out_valid=0, out_col=0, out_row=0, busy=0, done=0, x=y=0.
- rst has priority over every other input. rst mid-frame aborts the frame with no done pulse; the next frame needs a new start.
- start accepted at cycle t → busy=1 and in_ready=out_ready from t+1.
- Pixel-to-window latency is one cycle: accept at t → out_valid at t+1. This matches the one-cycle read latency of the pixel buffers.
- Backpressure:
  - out_ready=0 forces in_ready=0 in the same cycle, so no accept and no window that cycle.
  - An already-registered out_valid is not withdrawn.
- Last-pixel accept at t:
  - Final out_valid at t+1, coincident with done=1 and busy=0.
  - IDLE at t+2. A start at t+2 begins the next frame.
- in_valid gaps stall all counters. Address and window state are preserved across arbitrary stalls.

## Test plan
- Clean frame, F=3, I=5, start then 25 back-to-back pixels:
  - First out_valid follows the 13th accept, with out_col=0, out_row=0.
  - 9 out_valid pulses in total; the last has out_col=2, out_row=2.
  - done follows the 25th accept by one cycle, coincident with the final out_valid.
- Address wrap, F=3, I=5 (D=3):
  - wr_addr sequence 0,1,2,0,1…; rd_addr sequence 1,2,0,1,2…, one step per accept.
  - Both unchanged during 4-cycle in_valid gaps.
- Backpressure: hold out_ready=0 for 3 cycles mid-row.
  - in_ready=0 and buf_en=0 throughout.
  - Counters frozen; still 9 windows with correct coordinates.
- Reset mid-frame: rst after 10 accepts.
  - Next cycle all outputs at reset values and no done.
  - A subsequent start plus 25 pixels gives a normal frame.
- Start handling:
  - Pulse start during RUN: ignored, no counter disturbance.
  - Pulse start in the cycle done is high (DONE): ignored.
  - Pulse start one cycle later (IDLE): accepted.
- Minimum and square cases:
  - F=I=3: a single window with out_col=out_row=0 after the 9th accept.
  - D=1: wr_addr=rd_addr=0 for the whole frame.

Source files
------------

// File: rtl/conv_window_sequencer_if.sv
// Pixel-stream handshake and window-report bundle between the source,
// the sequencer and the convolution engine.
interface conv_window_sequencer_if #(
    parameter int unsigned A = 5
) ();
    logic         in_valid;
    logic         in_ready;
    logic         out_ready;
    logic         out_valid;
    logic [A-1:0] out_col;
    logic [A-1:0] out_row;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_col,
        output out_row
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_col,
        input  out_row
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Frame sequencer for the sliding-window convolution: drives line-buffer
// enable/addresses and flags each complete FILTER_SIZE x FILTER_SIZE window.
module conv_window_sequencer #(
    parameter int unsigned FILTER_SIZE = 3,
    parameter int unsigned IMAGE_SIZE  = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    conv_window_sequencer_if.master       hs,
    output logic                          buf_en,
    output logic [$clog2(IMAGE_SIZE)-1:0] wr_addr,
    output logic [$clog2(IMAGE_SIZE)-1:0] rd_addr,
    output logic                          busy,
    output logic                          done
);
    localparam int unsigned A       = $clog2(IMAGE_SIZE);
    localparam int unsigned F1      = FILTER_SIZE - 1;
    localparam int unsigned D       = IMAGE_SIZE - FILTER_SIZE + 1;
    localparam int unsigned LAST    = IMAGE_SIZE - 1;
    // With a single-entry line buffer the read address coincides with the write address.
    localparam int unsigned RD_INIT = (D > 1) ? 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         accept;
    logic [A-1:0] x;
    logic [A-1:0] y;
    logic         last_col;
    logic         last_row;
    logic         win_ok;

    assign last_col = (x == A'(LAST));
    assign last_row = (y == A'(LAST));
    assign win_ok   = (x >= A'(F1)) && (y >= A'(F1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake decode
    always_comb begin
        state_nxt   = state;
        hs.in_ready = 1'b0;
        accept      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                hs.in_ready = hs.out_ready;
                accept      = hs.in_valid & hs.out_ready;
                if (accept && last_col && last_row) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        buf_en = accept;
    end

    // Raster counters, circular buffer addresses and window report
    always_ff @(posedge clk) begin
        if (rst) begin
            x            <= '0;
            y            <= '0;
            wr_addr      <= '0;
            rd_addr      <= A'(RD_INIT);
            hs.out_valid <= 1'b0;
            hs.out_col   <= '0;
            hs.out_row   <= '0;
        end else begin
            hs.out_valid <= accept & win_ok;
            if (state == S_IDLE && start) begin
                x       <= '0;
                y       <= '0;
                wr_addr <= '0;
                rd_addr <= A'(RD_INIT);
            end else if (accept) begin
                x       <= last_col ? '0 : x + A'(1);
                wr_addr <= (wr_addr == A'(D - 1)) ? '0 : wr_addr + A'(1);
                rd_addr <= (rd_addr == A'(D - 1)) ? '0 : rd_addr + A'(1);
                if (last_col) begin
                    y <= last_row ? '0 : y + A'(1);
                end
                if (win_ok) begin
                    hs.out_col <= x - A'(F1);
                    hs.out_row <= y - A'(F1);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: a 5x5/3x3 instance against a
// reference model plus scoreboard, and a 3x3/3x3 instance for the single-window case.
module tb_conv_window_sequencer;
    localparam int unsigned I  = 5;
    localparam int unsigned F  = 3;
    localparam int unsigned D  = I - F + 1;
    localparam int unsigned A  = $clog2(I);
    localparam int unsigned IB = 3;
    localparam int unsigned FB = 3;
    localparam int unsigned AB = $clog2(IB);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          buf_en;
    logic          busy;
    logic          done;
    logic [A-1:0]  wr_addr;
    logic [A-1:0]  rd_addr;

    logic          b_start;
    logic          b_buf_en;
    logic          b_busy;
    logic          b_done;
    logic [AB-1:0] b_wr_addr;
    logic [AB-1:0] b_rd_addr;

    always #5 clk = ~clk;

    conv_window_sequencer_if #(.A(A))  hs_a ();
    conv_window_sequencer_if #(.A(AB)) hs_b ();

    conv_window_sequencer #(.FILTER_SIZE(F), .IMAGE_SIZE(I)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hs      (hs_a),
        .buf_en  (buf_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done)
    );

    conv_window_sequencer #(.FILTER_SIZE(FB), .IMAGE_SIZE(IB)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (b_start),
        .hs      (hs_b),
        .buf_en  (b_buf_en),
        .wr_addr (b_wr_addr),
        .rd_addr (b_rd_addr),
        .busy    (b_busy),
        .done    (b_done)
    );

    typedef struct {
        int unsigned col;
        int unsigned row;
    } win_t;

    typedef struct {
        logic         st;
        logic         v;
        logic         ordy;
        logic         exp_ir;
        logic [A-1:0] exp_wr;
        logic [A-1:0] exp_rd;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model of the 5x5 instance
    int unsigned m_state, m_x, m_y, m_wr, m_rd, m_col, m_row;
    logic        m_ov;
    int unsigned n_acc, n_win, first_win_acc, last_col, last_row;
    win_t        sb[$];
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 0; m_y = 0; m_wr = 0; m_rd = 1 % D;
        m_ov = 1'b0; m_col = 0; m_row = 0;
        sb.delete();
    endtask

    // One clock: drive, sample at negedge against the model, advance model, cross posedge.
    task automatic cyc(input logic v, input logic ordy, input logic st,
                       output logic ir_s, output logic [A-1:0] wr_s, output logic [A-1:0] rd_s);
        win_t w;
        logic exp_ir;
        logic acc;
        start = st; hs_a.in_valid = v; hs_a.out_ready = ordy;
        @(negedge clk);
        ir_s = hs_a.in_ready; wr_s = wr_addr; rd_s = rd_addr;
        exp_ir = (m_state == 1) && ordy;
        acc = v & exp_ir;
        chk("in_ready",  32'(hs_a.in_ready),  32'(exp_ir));
        chk("buf_en",    32'(buf_en),         32'(acc));
        chk("wr_addr",   32'(wr_addr),        m_wr);
        chk("rd_addr",   32'(rd_addr),        m_rd);
        chk("busy",      32'(busy),           32'(m_state == 1));
        chk("done",      32'(done),           32'(m_state == 2));
        chk("out_valid", 32'(hs_a.out_valid), 32'(m_ov));
        chk("out_col",   32'(hs_a.out_col),   m_col);
        chk("out_row",   32'(hs_a.out_row),   m_row);
        if (hs_a.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: got unexpected window col %0d row %0d required none",
                         hs_a.out_col, hs_a.out_row);
            end else begin
                w = sb.pop_front();
                chk("sb_col", 32'(hs_a.out_col), w.col);
                chk("sb_row", 32'(hs_a.out_row), w.row);
                if (n_win == 0) first_win_acc = n_acc;
                n_win++;
                last_col = 32'(hs_a.out_col);
                last_row = 32'(hs_a.out_row);
            end
        end
        m_ov = 1'b0;
        case (m_state)
            0: if (st) begin
                m_state = 1; m_x = 0; m_y = 0; m_wr = 0; m_rd = 1 % D;
            end
            1: if (acc) begin
                n_acc++;
                if (m_x >= F - 1 && m_y >= F - 1) begin
                    m_ov = 1'b1;
                    m_col = m_x - (F - 1);
                    m_row = m_y - (F - 1);
                    sb.push_back('{m_col, m_row});
                end
                if (m_x == I - 1 && m_y == I - 1) m_state = 2;
                m_wr = (m_wr + 1) % D;
                m_rd = (m_rd + 1) % D;
                if (m_x == I - 1) begin
                    m_x = 0;
                    m_y = (m_y + 1) % I;
                end else begin
                    m_x = m_x + 1;
                end
            end
            default: m_state = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic ordy, input logic st);
        logic         ir;
        logic [A-1:0] wr;
        logic [A-1:0] rd;
        cyc(v, ordy, st, ir, wr, rd);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; hs_a.in_valid = 1'b1; hs_a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic finish_frame();
        for (int k = 0; k < 100 && m_state == 1; k++) step(1'b1, 1'b1, 1'b0);
        if (m_state != 2) begin
            checks++; errors++;
            $display("FAIL frame_end: got no last-pixel accept within 100 cycles required one");
        end
    endtask

    initial begin
        logic         ir;
        logic [A-1:0] wr;
        logic [A-1:0] rd;

        rst = 1'b1; start = 1'b0; hs_a.in_valid = 1'b0; hs_a.out_ready = 1'b0;
        b_start = 1'b0; hs_b.in_valid = 1'b0; hs_b.out_ready = 1'b0;
        n_acc = 0; n_win = 0; first_win_acc = 0; last_col = 0; last_row = 0;
        model_reset();

        // {start, in_valid, out_ready, exp in_ready, exp wr_addr, exp rd_addr}
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 3'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 3'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 3'd0};

        do_reset();
        // Reset values on both instances
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b_rst_in_ready",  32'(hs_b.in_ready),  32'd0);
        chk("b_rst_wr_addr",   32'(b_wr_addr),      32'd0);
        chk("b_rst_rd_addr",   32'(b_rd_addr),      32'd0);
        chk("b_rst_out_valid", 32'(hs_b.out_valid), 32'd0);
        chk("b_rst_busy",      32'(b_busy),         32'd0);
        chk("b_rst_done",      32'(b_done),         32'd0);
        @(posedge clk);
        #1;

        // Address wrap, in_valid gaps and out_ready backpressure from a table
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].v, tbl[i].ordy, tbl[i].st, ir, wr, rd);
            chk($sformatf("tbl%0d_in_ready", i), 32'(ir), 32'(tbl[i].exp_ir));
            chk($sformatf("tbl%0d_wr_addr", i),  32'(wr), 32'(tbl[i].exp_wr));
            chk($sformatf("tbl%0d_rd_addr", i),  32'(rd), 32'(tbl[i].exp_rd));
        end
        // Start during RUN is ignored, then backpressure right after the first window
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
        finish_frame();
        // Start in the DONE cycle is ignored; start in the following IDLE cycle is taken
        step(1'b0, 1'b1, 1'b1);
        chk("bp_windows", n_win, 32'd9);
        chk("bp_last_col", last_col, 32'd2);
        chk("bp_last_row", last_row, 32'd2);
        step(1'b0, 1'b1, 1'b1);

        // Clean back-to-back frame
        n_acc = 0; n_win = 0;
        for (int k = 0; k < 25; k++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("clean_first_window_acc", first_win_acc, 32'd13);
        chk("clean_windows", n_win, 32'd9);
        chk("clean_last_col", last_col, 32'd2);
        chk("clean_last_row", last_row, 32'd2);

        // Reset after 10 accepts aborts with no done, then a normal frame
        step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        n_acc = 0; n_win = 0;
        for (int k = 0; k < 25; k++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("post_rst_first_window_acc", first_win_acc, 32'd13);
        chk("post_rst_windows", n_win, 32'd9);
        chk("post_rst_queue_empty", sb.size(), 32'd0);

        // F = I = 3: single window, single-entry line buffer
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0; hs_b.in_valid = 1'b1; hs_b.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("b_px%0d_in_ready", k),  32'(hs_b.in_ready),  32'd1);
            chk($sformatf("b_px%0d_wr_addr", k),   32'(b_wr_addr),      32'd0);
            chk($sformatf("b_px%0d_rd_addr", k),   32'(b_rd_addr),      32'd0);
            chk($sformatf("b_px%0d_out_valid", k), 32'(hs_b.out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        hs_b.in_valid = 1'b0;
        @(negedge clk);
        chk("b_win_valid", 32'(hs_b.out_valid), 32'd1);
        chk("b_win_col",   32'(hs_b.out_col),   32'd0);
        chk("b_win_row",   32'(hs_b.out_row),   32'd0);
        chk("b_done",      32'(b_done),         32'd1);
        chk("b_busy",      32'(b_busy),         32'd0);
        chk("b_wr_end",    32'(b_wr_addr),      32'd0);
        chk("b_rd_end",    32'(b_rd_addr),      32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b_idle_valid", 32'(hs_b.out_valid), 32'd0);
        chk("b_idle_done",  32'(b_done),         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
